tbuf_bus_arbiter: RTL and testbench

Round-robin owner controller for a shared W-bit tri-state pad bus built from an array of OBUFT-style buffers (T high = high-Z). It grants the bus to one of N requesters and steers that requester's data onto the buffer I inputs. It drives the common buffer T so the pads are never driven during an ownership change, inserting a programmable dead (turnaround) interval. It sits between the internal bus masters and the output-buffer column; global tri-state (GTS) stays inside the buffers and is not handled here.

---
 rtl/tbuf_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_tbuf_bus_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tbuf_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tbuf_bus_arbiter
// Brief    : Round-robin owner controller for a tri-state pad bus with a
//            programmable dead interval between owners.
// Revision : 1.0 - initial release
// ============================================================================
module tbuf_bus_arbiter #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TURN    = 1,
    parameter int MAXHOLD = 16
) (
    input  logic             C,
    input  logic             R,
    input  logic [N-1:0]     REQ,
    input  logic [N*W-1:0]   DIN,
    output logic [N-1:0]     GNT,
    output logic [W-1:0]     PAD_I,
    output logic             PAD_T,
    output logic             TURNING
);

    localparam int         c_IW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0] c_MAXHOLD = 8'(MAXHOLD);
    localparam logic [3:0] c_TURN    = 4'(TURN);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_DRIVE = 2'd1;
    localparam logic [1:0] c_S_TURN  = 2'd2;

    logic [1:0]      r_state,   w_state;
    logic [N-1:0]    r_gnt,     w_gnt;
    logic [c_IW-1:0] r_ptr,     w_ptr;
    logic [7:0]      r_hold,    w_hold;
    logic [3:0]      r_turn,    w_turn;
    logic            r_pad_t,   w_pad_t;
    logic            r_turning, w_turning;

    logic            w_found;
    logic [N-1:0]    w_win_oh;
    logic [c_IW-1:0] w_next_ptr;
    logic            w_do_grant;
    logic            w_owner_req;
    logic            w_others;
    logic [W-1:0]    w_pad_i;

    // Rotating priority search: first set REQ bit at or above the pointer.
    always_comb begin
        w_found    = 1'b0;
        w_win_oh   = '0;
        w_next_ptr = '0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = int'(r_ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!w_found && REQ[idx]) begin
                w_found       = 1'b1;
                w_win_oh[idx] = 1'b1;
                w_next_ptr    = (idx == N - 1) ? '0 : c_IW'(idx + 1);
            end
        end
    end

    assign w_owner_req = |(REQ & r_gnt);
    assign w_others    = |(REQ & ~r_gnt);

    always_comb begin
        w_state    = r_state;
        w_gnt      = r_gnt;
        w_ptr      = r_ptr;
        w_hold     = r_hold;
        w_turn     = r_turn;
        w_pad_t    = r_pad_t;
        w_turning  = r_turning;
        w_do_grant = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                w_gnt      = '0;
                w_pad_t    = 1'b1;
                w_turning  = 1'b0;
                w_do_grant = w_found;
            end
            c_S_DRIVE: begin
                if (!w_owner_req || ((r_hold == c_MAXHOLD) && w_others)) begin
                    w_state   = c_S_TURN;
                    w_gnt     = '0;
                    w_pad_t   = 1'b1;
                    w_turn    = 4'd1;
                    w_turning = 1'b1;
                end else if (r_hold != c_MAXHOLD) begin
                    w_hold = r_hold + 8'd1;
                end
            end
            c_S_TURN: begin
                if (r_turn == c_TURN) begin
                    w_state    = c_S_IDLE;
                    w_gnt      = '0;
                    w_pad_t    = 1'b1;
                    w_turning  = 1'b0;
                    w_do_grant = w_found;
                end else begin
                    w_turn = r_turn + 4'd1;
                end
            end
            default: begin
                w_state   = c_S_IDLE;
                w_gnt     = '0;
                w_pad_t   = 1'b1;
                w_turning = 1'b0;
            end
        endcase

        // A grant from IDLE or the last dead cycle goes straight to DRIVE.
        if (w_do_grant) begin
            w_state   = c_S_DRIVE;
            w_gnt     = w_win_oh;
            w_ptr     = w_next_ptr;
            w_hold    = 8'd1;
            w_pad_t   = 1'b0;
            w_turning = 1'b0;
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            r_state   <= c_S_IDLE;
            r_gnt     <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_turn    <= '0;
            r_pad_t   <= 1'b1;
            r_turning <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_gnt     <= w_gnt;
            r_ptr     <= w_ptr;
            r_hold    <= w_hold;
            r_turn    <= w_turn;
            r_pad_t   <= w_pad_t;
            r_turning <= w_turning;
        end
    end

    // Unregistered data path; forced to zero whenever the pads are released.
    always_comb begin
        w_pad_i = '0;
        for (int k = 0; k < N; k++) begin
            if (r_gnt[k] && !r_pad_t) w_pad_i = DIN[k*W +: W];
        end
    end

    assign GNT     = r_gnt;
    assign PAD_T   = r_pad_t;
    assign TURNING = r_turning;
    assign PAD_I   = w_pad_i;

endmodule
`default_nettype wire

// File: tb/tb_tbuf_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tbuf_bus_arbiter
// Brief    : Directed scenarios plus random traffic against an ownership model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tbuf_bus_arbiter;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int TURN    = 1;
    localparam int MAXHOLD = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] din = '0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   pad_i;
    logic           pad_t;
    logic           turning;

    tbuf_bus_arbiter #(.N(N), .W(W), .TURN(TURN), .MAXHOLD(MAXHOLD)) u_dut (
        .C       (clk),
        .R       (rst),
        .REQ     (req),
        .DIN     (din),
        .GNT     (gnt),
        .PAD_I   (pad_i),
        .PAD_T   (pad_t),
        .TURNING (turning)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Ownership model: owner index (-1 = nobody), cycles held, dead cycles left.
    int m_owner = -1;
    int m_held  = 0;
    int m_dead  = 0;
    int m_ptr   = 0;

    int           order[$];
    logic [N-1:0] prev_gnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_grant(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (r[k]) begin
                m_owner = k;
                m_held  = 1;
                m_ptr   = (k + 1) % N;
                return;
            end
        end
    endtask

    task automatic model_edge(input logic rs, input logic [N-1:0] r);
        if (rs) begin
            m_owner = -1; m_held = 0; m_dead = 0; m_ptr = 0;
        end else if (m_owner >= 0) begin
            logic [N-1:0] others;
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner] || (m_held >= MAXHOLD && others != 0)) begin
                m_owner = -1;
                m_dead  = TURN;
            end else if (m_held < MAXHOLD) begin
                m_held++;
            end
        end else if (m_dead > 1) begin
            m_dead--;
        end else begin
            m_dead = 0;
            if (r != 0) model_grant(r);
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_gnt;
        logic [W-1:0] e_pad_i;
        e_gnt   = '0;
        e_pad_i = '0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_pad_i        = din[m_owner*W +: W];
        end
        chk("gnt",     32'(gnt),     32'(e_gnt));
        chk("pad_t",   32'(pad_t),   32'(m_owner < 0));
        chk("pad_i",   32'(pad_i),   32'(e_pad_i));
        chk("turning", 32'(turning), 32'(m_dead > 0));
        chk("inv_onehot", 32'($countones(gnt) <= 1), 32'd1);
        chk("inv_drive_dead", 32'(!pad_t && turning), 32'd0);
        chk("inv_padi_hiz", pad_t ? 32'(pad_i) : 32'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(rst, req);
        #1;
        check_outputs();
        if (gnt != 0 && prev_gnt == 0) begin
            for (int k = 0; k < N; k++) if (gnt[k]) order.push_back(k);
        end
        prev_gnt = gnt;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset with every requester asking; bus must stay released.
        req = 4'b1111;
        do_reset(2);
        chk("rst_gnt",   32'(gnt),   32'h0);
        chk("rst_pad_t", 32'(pad_t), 32'h1);
        chk("rst_pad_i", 32'(pad_i), 32'h0);
        step();
        chk("rst_first_gnt", 32'(gnt), 32'h1);

        // Single owner for 10 cycles, then drop.
        do_reset(1);
        req = 4'b0100;
        din = 32'h11A52233;
        repeat (10) begin
            step();
            chk("single_gnt",   32'(gnt),   32'h4);
            chk("single_pad_i", 32'(pad_i), 32'hA5);
        end
        req = 4'b0000;
        step();
        chk("single_dead_t",   32'(pad_t),   32'h1);
        chk("single_dead_trn", 32'(turning), 32'h1);
        step();
        chk("single_idle_trn", 32'(turning), 32'h0);
        chk("single_idle_gnt", 32'(gnt),     32'h0);

        // Full contention from pointer 0.
        do_reset(1);
        order.delete();
        req = 4'b1111;
        din = 32'h44332211;
        repeat (27) step();
        chk("cont_count", 32'(order.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            int exp_k;
            exp_k = i % N;
            chk("cont_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(exp_k));
        end

        // Uncontended: owner keeps the bus past the hold limit.
        do_reset(1);
        req = 4'b0001;
        repeat (20) begin
            step();
            chk("solo_gnt", 32'(gnt), 32'h1);
        end

        // Reset in the middle of a drive.
        do_reset(1);
        req = 4'b0100;
        repeat (3) step();
        chk("mid_pre_gnt", 32'(gnt), 32'h4);
        rst = 1'b1;
        req = 4'b0101;
        step();
        chk("mid_rst_gnt",   32'(gnt),   32'h0);
        chk("mid_rst_pad_t", 32'(pad_t), 32'h1);
        rst = 1'b0;
        step();
        chk("mid_first_gnt", 32'(gnt), 32'h1);

        // Owner drops on the same edge the hold limit is reached.
        do_reset(1);
        req = 4'b0010;
        repeat (4) step();
        chk("lim_owner", 32'(gnt), 32'h2);
        req = 4'b1000;
        step();
        chk("lim_dead_trn", 32'(turning), 32'h1);
        chk("lim_dead_gnt", 32'(gnt),     32'h0);
        step();
        chk("lim_next_gnt", 32'(gnt), 32'h8);

        // Random traffic with sticky requests and occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(3) == 0) req[k] = ~req[k];
                din[k*W +: W] = W'($urandom);
            end
            rst = ($urandom_range(63) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
